// File: rtl/writeback_stage.sv
// Writeback stage: merges single-cycle ALU results and buffered long-latency
// results into the register file's single write port. It keeps a per-register
// pending scoreboard for decode hazard checks and a bypass of the value being
// written this cycle.
module writeback_stage #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        alu_valid_i,
  input  logic [4:0]  alu_rd_i,
  input  logic [31:0] alu_data_i,
  input  logic        mem_issue_valid_i,
  input  logic [4:0]  mem_issue_rd_i,
  output logic        mem_issue_ready_o,
  input  logic        mem_valid_i,
  input  logic [4:0]  mem_rd_i,
  input  logic [31:0] mem_data_i,
  output logic        mem_ready_o,
  output logic [4:0]  rd_sel_o,
  output logic [31:0] rd_in_o,
  output logic        rd_w_o,
  input  logic [4:0]  rs1_sel_i,
  input  logic [4:0]  rs2_sel_i,
  output logic        rs1_busy_o,
  output logic        rs2_busy_o,
  output logic        fwd1_hit_o,
  output logic        fwd2_hit_o,
  output logic [31:0] fwd1_data_o,
  output logic [31:0] fwd2_data_o
);

  localparam int          PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW:0] DEPTH_C = (PW + 1)'(FIFO_DEPTH);

  // Bit 0 is held at zero so x0 never reads as pending.
  logic [31:0]   pend_q, pend_d;

  logic [4:0]    fifo_rd_q   [FIFO_DEPTH];
  logic [31:0]   fifo_data_q [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [PW:0]   cnt_q, cnt_d;

  logic          rd_w_q, rd_w_d;
  logic [4:0]    rd_sel_q, rd_sel_d;
  logic [31:0]   rd_in_q, rd_in_d;

  logic          issue_fire;
  logic          push;
  logic          pop;
  logic [4:0]    head_rd;
  logic [31:0]   head_data;

  assign head_rd    = fifo_rd_q[rptr_q];
  assign head_data  = fifo_data_q[rptr_q];

  // mem_ready looks only at the registered count, so a pop never changes it
  // combinationally.
  assign mem_ready_o       = (cnt_q < DEPTH_C);
  assign mem_issue_ready_o = !((mem_issue_rd_i != 5'd0) && pend_q[mem_issue_rd_i]);

  assign issue_fire = mem_issue_valid_i && mem_issue_ready_o && (mem_issue_rd_i != 5'd0);
  assign push       = mem_valid_i && mem_ready_o;
  // ALU has fixed priority; the FIFO head drains only in ALU-idle cycles.
  assign pop        = !alu_valid_i && (cnt_q != '0);

  // Scoreboard update: clear on pop, then set on issue so a set wins a collision.
  always_comb begin
    pend_d = pend_q;
    if (pop) pend_d[head_rd] = 1'b0;
    if (issue_fire) pend_d[mem_issue_rd_i] = 1'b1;
    pend_d[0] = 1'b0;
  end

  // Commit arbitration into the output register; rd 0 commits write nothing.
  always_comb begin
    rd_w_d   = 1'b0;
    rd_sel_d = rd_sel_q;
    rd_in_d  = rd_in_q;
    if (alu_valid_i) begin
      rd_w_d   = (alu_rd_i != 5'd0);
      rd_sel_d = (alu_rd_i != 5'd0) ? alu_rd_i : 5'd0;
      rd_in_d  = (alu_rd_i != 5'd0) ? alu_data_i : 32'd0;
    end else if (pop) begin
      rd_w_d   = (head_rd != 5'd0);
      rd_sel_d = (head_rd != 5'd0) ? head_rd : 5'd0;
      rd_in_d  = (head_rd != 5'd0) ? head_data : 32'd0;
    end
  end

  // FIFO occupancy; simultaneous push and pop leave the count unchanged.
  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state: scoreboard, FIFO pointers/count and the output register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q   <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      rd_w_q   <= 1'b0;
      rd_sel_q <= 5'd0;
      rd_in_q  <= 32'd0;
    end else begin
      pend_q   <= pend_d;
      cnt_q    <= cnt_d;
      rd_w_q   <= rd_w_d;
      rd_sel_q <= rd_sel_d;
      rd_in_q  <= rd_in_d;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // FIFO payload storage; validity is tracked by the pointers, so no reset.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_rd_q[wptr_q]   <= mem_rd_i;
      fifo_data_q[wptr_q] <= mem_data_i;
    end
  end

  assign rd_w_o      = rd_w_q;
  assign rd_sel_o    = rd_sel_q;
  assign rd_in_o     = rd_in_q;

  assign rs1_busy_o  = (rs1_sel_i != 5'd0) && pend_q[rs1_sel_i];
  assign rs2_busy_o  = (rs2_sel_i != 5'd0) && pend_q[rs2_sel_i];
  assign fwd1_hit_o  = rd_w_q && (rd_sel_q == rs1_sel_i) && (rs1_sel_i != 5'd0);
  assign fwd2_hit_o  = rd_w_q && (rd_sel_q == rs2_sel_i) && (rs2_sel_i != 5'd0);
  assign fwd1_data_o = rd_in_q;
  assign fwd2_data_o = rd_in_q;

`ifndef SYNTHESIS
  // A long-latency result must target a register that was issued and is pending.
  always @(posedge clk_i) begin
    if (rst_ni && push && (mem_rd_i != 5'd0)) begin
      assert (pend_q[mem_rd_i])
        else $error("writeback_stage: mem result to rd %0d without pending issue", mem_rd_i);
    end
  end
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Directed testbench for writeback_stage with a commit scoreboard.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        mem_issue_valid;
  logic [4:0]  mem_issue_rd;
  logic        mem_issue_ready;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic [4:0]  rd_sel;
  logic [31:0] rd_in;
  logic        rd_w;
  logic [4:0]  rs1_sel, rs2_sel;
  logic        rs1_busy, rs2_busy, fwd1_hit, fwd2_hit;
  logic [31:0] fwd1_data, fwd2_data;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t mfifo[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  writeback_stage #(.FIFO_DEPTH(2)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .alu_valid_i(alu_valid), .alu_rd_i(alu_rd), .alu_data_i(alu_data),
    .mem_issue_valid_i(mem_issue_valid), .mem_issue_rd_i(mem_issue_rd),
    .mem_issue_ready_o(mem_issue_ready),
    .mem_valid_i(mem_valid), .mem_rd_i(mem_rd), .mem_data_i(mem_data),
    .mem_ready_o(mem_ready),
    .rd_sel_o(rd_sel), .rd_in_o(rd_in), .rd_w_o(rd_w),
    .rs1_sel_i(rs1_sel), .rs2_sel_i(rs2_sel),
    .rs1_busy_o(rs1_busy), .rs2_busy_o(rs2_busy),
    .fwd1_hit_o(fwd1_hit), .fwd2_hit_o(fwd2_hit),
    .fwd1_data_o(fwd1_data), .fwd2_data_o(fwd2_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  // One clock: predict this edge's commit from the model, then check it.
  task automatic tick();
    logic        exp_v;
    logic [4:0]  exp_rd;
    logic [31:0] exp_d;
    ent_t        e;
    exp_v  = 1'b0;
    exp_rd = 5'd0;
    exp_d  = 32'd0;
    if (alu_valid) begin
      if (alu_rd != 5'd0) begin
        exp_v = 1'b1; exp_rd = alu_rd; exp_d = alu_data;
      end
    end else if (mfifo.size() > 0) begin
      e = mfifo.pop_front();
      if (e.rd != 5'd0) begin
        exp_v = 1'b1; exp_rd = e.rd; exp_d = e.data;
      end
    end
    if (mem_valid) begin
      e.rd = mem_rd; e.data = mem_data;
      mfifo.push_back(e);
    end
    @(posedge clk);
    #1;
    chk("rd_w", 32'(rd_w), 32'(exp_v));
    if (exp_v) begin
      chk("commit_rd", 32'(rd_sel), 32'(exp_rd));
      chk("commit_data", rd_in, exp_d);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rd_w"}, 32'(rd_w), 32'd0);
    chk({tag, "_rd_sel"}, 32'(rd_sel), 32'd0);
    chk({tag, "_rd_in"}, rd_in, 32'd0);
    chk({tag, "_mem_ready"}, 32'(mem_ready), 32'd1);
    chk({tag, "_issue_ready"}, 32'(mem_issue_ready), 32'd1);
    chk({tag, "_rs1_busy"}, 32'(rs1_busy), 32'd0);
    chk({tag, "_rs2_busy"}, 32'(rs2_busy), 32'd0);
    chk({tag, "_fwd1_hit"}, 32'(fwd1_hit), 32'd0);
    chk({tag, "_fwd2_hit"}, 32'(fwd2_hit), 32'd0);
    chk({tag, "_fwd1_data"}, fwd1_data, 32'd0);
    chk({tag, "_fwd2_data"}, fwd2_data, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
    mem_issue_valid = 1'b0; mem_issue_rd = 5'd0;
    mem_valid = 1'b0; mem_rd = 5'd0; mem_data = 32'd0;
    rs1_sel = 5'd3; rs2_sel = 5'd3;
    #22;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // ALU only
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234_5678; rs1_sel = 5'd5;
    tick();
    chk("alu_fwd1_hit", 32'(fwd1_hit), 32'd1);
    chk("alu_fwd1_data", fwd1_data, 32'h1234_5678);
    alu_valid = 1'b0;
    tick();
    chk("alu_fwd1_hit_after", 32'(fwd1_hit), 32'd0);

    // Scoreboard
    mem_issue_valid = 1'b1; mem_issue_rd = 5'd7; #1;
    chk("sb_issue_ready", 32'(mem_issue_ready), 32'd1);
    tick();
    rs2_sel = 5'd7; #1;
    chk("sb_rs2_busy", 32'(rs2_busy), 32'd1);
    chk("sb_reissue_ready", 32'(mem_issue_ready), 32'd0);
    mem_issue_valid = 1'b0;
    mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'hDEAD_BEEF;
    tick();
    mem_valid = 1'b0;
    tick();
    chk("sb_rs2_busy_clear", 32'(rs2_busy), 32'd0);
    chk("sb_fwd2_hit", 32'(fwd2_hit), 32'd1);
    chk("sb_fwd2_data", fwd2_data, 32'hDEAD_BEEF);
    tick();

    // Priority / starvation
    mem_issue_valid = 1'b1; mem_issue_rd = 5'd3;
    tick();
    mem_issue_valid = 1'b0;
    mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'hAAAA_0003;
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1'b1; alu_rd = 5'(10 + i); alu_data = 32'hC000_0000 + 32'(i);
      tick();
      mem_valid = 1'b0;
    end
    rs1_sel = 5'd3; #1;
    chk("prio_rd3_still_busy", 32'(rs1_busy), 32'd1);
    alu_valid = 1'b0;
    tick();
    chk("prio_rd3_busy_clear", 32'(rs1_busy), 32'd0);
    tick();

    // FIFO full
    for (int r = 1; r <= 3; r++) begin
      mem_issue_valid = 1'b1; mem_issue_rd = 5'(r);
      tick();
    end
    mem_issue_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'h0000_0020;
    mem_valid = 1'b1; mem_rd = 5'd1; mem_data = 32'h1111_1111;
    tick();
    chk("full_ready_one", 32'(mem_ready), 32'd1);
    mem_rd = 5'd2; mem_data = 32'h2222_2222;
    tick();
    mem_valid = 1'b0;
    chk("full_ready_low", 32'(mem_ready), 32'd0);
    tick();
    chk("full_ready_held", 32'(mem_ready), 32'd0);
    alu_valid = 1'b0;
    tick();
    chk("full_ready_back", 32'(mem_ready), 32'd1);
    tick();
    tick();

    // x0
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF_FFFF;
    tick();
    chk("x0_rd_sel", 32'(rd_sel), 32'd0);
    chk("x0_rd_in", rd_in, 32'd0);
    alu_valid = 1'b0;
    mem_issue_valid = 1'b1; mem_issue_rd = 5'd0; #1;
    chk("x0_issue_ready", 32'(mem_issue_ready), 32'd1);
    tick();
    mem_issue_valid = 1'b0;
    mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'h0000_0055;
    tick();
    mem_valid = 1'b0;
    tick();
    rs1_sel = 5'd3; rs2_sel = 5'd0; #1;
    chk("x0_pend3_kept", 32'(rs1_busy), 32'd1);
    chk("x0_rs2_zero_busy", 32'(rs2_busy), 32'd0);
    chk("x0_mem_ready", 32'(mem_ready), 32'd1);
    tick();

    // Reset mid-flight: pend {3,4,5}, two FIFO entries
    for (int r = 4; r <= 5; r++) begin
      mem_issue_valid = 1'b1; mem_issue_rd = 5'(r);
      tick();
    end
    mem_issue_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd21; alu_data = 32'h0000_0021;
    mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'h4444_4444;
    tick();
    mem_rd = 5'd5; mem_data = 32'h5555_5555;
    tick();
    mem_valid = 1'b0;
    rs1_sel = 5'd4; rs2_sel = 5'd5; #1;
    chk("rst_pre_busy1", 32'(rs1_busy), 32'd1);
    chk("rst_pre_busy2", 32'(rs2_busy), 32'd1);
    chk("rst_pre_ready", 32'(mem_ready), 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    mem_issue_rd = 5'd3;
    rs1_sel = 5'd21; rs2_sel = 5'd4; #1;
    check_reset_outputs("midrst");
    mfifo.delete();
    alu_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int r = 3; r <= 5; r++) begin
      mem_issue_valid = 1'b1; mem_issue_rd = 5'(r); #1;
      chk("post_rst_issue_ready", 32'(mem_issue_ready), 32'd1);
      tick();
    end
    mem_issue_valid = 1'b0;
    rs1_sel = 5'd4; #1;
    chk("post_rst_busy", 32'(rs1_busy), 32'd1);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
